// File: rtl/stream_fork_using_double_buffer_and_fifos_pkg.sv
// Shared definitions for the stream fork: occupancy width helper, double buffer depth and state encoding.
package stream_fork_pkg;

  localparam int unsigned DB_DEPTH = 2;

  typedef enum logic [1:0] {
    DB_EMPTY,
    DB_ONE,
    DB_TWO
  } db_state_e;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_fork_using_double_buffer_and_fifos_if.sv
// Handshake bundle for the stream fork: input stream plus outputs a and b.
// Occupancy counts exist only when STREAM_FORK_OCCUPANCY_EN is defined.
interface stream_fork_using_double_buffer_and_fifos_if #(
  parameter int unsigned width = 8
`ifdef STREAM_FORK_OCCUPANCY_EN
  , parameter int unsigned cw = 4
`endif
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_data;
  logic             a_valid;
  logic             a_ready;
  logic [width-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [width-1:0] b_data;
`ifdef STREAM_FORK_OCCUPANCY_EN
  logic [cw-1:0]    a_count;
  logic [cw-1:0]    b_count;

  modport master (output in_valid, in_data, a_ready, b_ready,
                  input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count);
  modport slave  (input  in_valid, in_data, a_ready, b_ready,
                  output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count);
`else
  modport master (output in_valid, in_data, a_ready, b_ready,
                  input  in_ready, a_valid, a_data, b_valid, b_data);
  modport slave  (input  in_valid, in_data, a_ready, b_ready,
                  output in_ready, a_valid, a_data, b_valid, b_data);
`endif
endinterface

// File: rtl/stream_fork_using_double_buffer_and_fifos_fifo.sv
// Counter-based FIFO with a registered output word; count covers memory plus output register.
module stream_fork_fifo_with_counter
  import stream_fork_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [width-1:0]              push_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [width-1:0]              out_data_o,
  output logic [occ_width(depth)-1:0]   count_o
);
  localparam int unsigned CW = occ_width(depth);
  localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, mem_cnt;
  logic             out_valid_q, out_valid_d;
  logic [width-1:0] out_data_q, out_data_d;
  logic             pop, load;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // The output register refills from memory only on the edge after a push, so no fall-through.
  always_comb begin
    pop         = out_valid_q & out_ready_i;
    mem_cnt     = count_q - CW'(out_valid_q);
    load        = (mem_cnt != '0) & (~out_valid_q | pop);
    wr_ptr_d    = push_i ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = load ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    out_valid_d = load | (out_valid_q & ~pop);
    out_data_d  = load ? mem_q[rd_ptr_q] : out_data_q;
    count_d     = count_q;
    if (push_i & ~pop)      count_d = count_q + 1'b1;
    else if (~push_i & pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign count_o     = count_q;

endmodule

// File: rtl/stream_fork_using_double_buffer_and_fifos.sv
// Broadcast fork: double-buffered input copied in lockstep into two independent FIFOs.
// Define STREAM_FORK_OCCUPANCY_EN to expose a_count/b_count on the interface.
module stream_fork_using_double_buffer_and_fifos
  import stream_fork_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 10
) (
  input  logic clk,
  input  logic rst,
  stream_fork_using_double_buffer_and_fifos_if.slave bus
);
  localparam int unsigned CW = occ_width(depth);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  db_state_e        state_q, state_d;
  logic [width-1:0] db_q [DB_DEPTH];
  logic [width-1:0] db_d [DB_DEPTH];
  logic             in_ready_q, in_ready_d;
  logic             in_fire, fork_valid, fork_ready, fork_fire;
  logic [CW-1:0]    a_cnt, b_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DB_EMPTY;
      db_q       <= '{default: '0};
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      db_q       <= db_d;
      in_ready_q <= in_ready_d;
    end
  end

  // db_q[0] is always the head; a simultaneous push and pop in DB_ONE replaces it.
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    in_fire = bus.in_valid & in_ready_q;
    unique case (state_q)
      DB_EMPTY: if (in_fire) begin
        state_d  = DB_ONE;
        db_d[0]  = bus.in_data;
      end
      DB_ONE: begin
        if (in_fire & fork_fire) db_d[0] = bus.in_data;
        else if (in_fire) begin
          state_d = DB_TWO;
          db_d[1] = bus.in_data;
        end else if (fork_fire) state_d = DB_EMPTY;
      end
      DB_TWO: if (fork_fire) begin
        state_d = DB_ONE;
        db_d[0] = db_q[1];
      end
      default: state_d = DB_EMPTY;
    endcase
    in_ready_d = (state_d != DB_TWO);
  end

  always_comb begin
    fork_valid = (state_q != DB_EMPTY);
    fork_ready = (a_cnt != FULL_CNT) & (b_cnt != FULL_CNT);
    fork_fire  = fork_valid & fork_ready;
  end

  assign bus.in_ready = in_ready_q;

  stream_fork_fifo_with_counter #(.width(width), .depth(depth)) u_fifo_a (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (fork_fire),
    .push_data_i (db_q[0]),
    .out_valid_o (bus.a_valid),
    .out_ready_i (bus.a_ready),
    .out_data_o  (bus.a_data),
    .count_o     (a_cnt)
  );

  stream_fork_fifo_with_counter #(.width(width), .depth(depth)) u_fifo_b (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (fork_fire),
    .push_data_i (db_q[0]),
    .out_valid_o (bus.b_valid),
    .out_ready_i (bus.b_ready),
    .out_data_o  (bus.b_data),
    .count_o     (b_cnt)
  );

`ifdef STREAM_FORK_OCCUPANCY_EN
  assign bus.a_count = a_cnt;
  assign bus.b_count = b_cnt;
`endif

endmodule

// File: tb/tb_stream_fork_using_double_buffer_and_fifos.sv
// Directed bench for the stream fork; count checks compile in with STREAM_FORK_OCCUPANCY_EN.
module tb_stream_fork_using_double_buffer_and_fifos;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] src[$];
  logic [7:0] aq[$];
  logic [7:0] bq[$];
  logic [7:0] got;

`ifdef STREAM_FORK_OCCUPANCY_EN
  stream_fork_using_double_buffer_and_fifos_if #(.width(8), .cw(4)) bus ();
`else
  stream_fork_using_double_buffer_and_fifos_if #(.width(8)) bus ();
`endif

  stream_fork_using_double_buffer_and_fifos #(.width(8), .depth(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic load_src();
    bus.in_valid = (src.size() != 0);
    bus.in_data  = (src.size() != 0) ? src[0] : 8'h00;
  endtask

  // One clock: record handshakes seen before the edge, then advance the source.
  task automatic step();
    logic acc;
    acc = bus.in_valid & bus.in_ready;
    if (bus.a_valid & bus.a_ready) aq.push_back(bus.a_data);
    if (bus.b_valid & bus.b_ready) bq.push_back(bus.b_data);
    @(posedge clk);
    #1;
    if (acc) void'(src.pop_front());
    load_src();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1; bus.in_data = 8'hEE; bus.a_ready = 1'b1; bus.b_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_valid got=%0b exp=0", bus.a_valid); end
    n_cmp++; if (bus.b_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_valid got=%0b exp=0", bus.b_valid); end
    n_cmp++; if (bus.a_data !== 8'h00) begin n_bad++; $display("FAIL reset_a_data got=%h exp=00", bus.a_data); end
    n_cmp++; if (bus.b_data !== 8'h00) begin n_bad++; $display("FAIL reset_b_data got=%h exp=00", bus.b_data); end
`ifdef STREAM_FORK_OCCUPANCY_EN
    n_cmp++; if (bus.a_count !== 4'd0) begin n_bad++; $display("FAIL reset_a_count got=%0d exp=0", bus.a_count); end
`endif
    bus.in_valid = 1'b0;
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    aq.delete(); bq.delete();
    src = '{8'h5A};
    load_src();
    for (int e = 0; e <= 3; e++) begin
      step();
      n_cmp++;
      if (bus.a_valid !== (e == 2)) begin n_bad++; $display("FAIL single_a_valid edge=%0d got=%0b exp=%0b", e, bus.a_valid, e == 2); end
      n_cmp++;
      if (bus.b_valid !== (e == 2)) begin n_bad++; $display("FAIL single_b_valid edge=%0d got=%0b exp=%0b", e, bus.b_valid, e == 2); end
    end
    n_cmp++; if (aq.size() != 1 || aq[0] !== 8'h5A) begin n_bad++; $display("FAIL single_a_data got_n=%0d exp 1 word 5a", aq.size()); end
    n_cmp++; if (bq.size() != 1 || bq[0] !== 8'h5A) begin n_bad++; $display("FAIL single_b_data got_n=%0d exp 1 word 5a", bq.size()); end
  endtask

  task automatic test_back_to_back();
    aq.delete(); bq.delete();
    for (int i = 1; i <= 20; i++) src.push_back(8'(i));
    load_src();
    for (int e = 0; e <= 22; e++) begin
      step();
      if (e >= 2 && e <= 21) begin
        n_cmp++;
        if ({bus.a_valid, bus.a_data} !== {1'b1, 8'(e - 1)}) begin
          n_bad++; $display("FAIL stream_a edge=%0d got=%0b/%h exp=1/%h", e, bus.a_valid, bus.a_data, 8'(e - 1));
        end
        n_cmp++;
        if ({bus.b_valid, bus.b_data} !== {1'b1, 8'(e - 1)}) begin
          n_bad++; $display("FAIL stream_b edge=%0d got=%0b/%h exp=1/%h", e, bus.b_valid, bus.b_data, 8'(e - 1));
        end
      end else begin
        n_cmp++;
        if (bus.a_valid !== 1'b0) begin n_bad++; $display("FAIL stream_a_idle edge=%0d got=%0b exp=0", e, bus.a_valid); end
      end
    end
  endtask

  task automatic test_stall_b();
    aq.delete(); bq.delete();
    bus.a_ready = 1'b1; bus.b_ready = 1'b0;
    for (int i = 1; i <= 15; i++) src.push_back(8'(i));
    load_src();
    repeat (40) step();
    n_cmp++; if (aq.size() != 10) begin n_bad++; $display("FAIL stall_a_count_words got=%0d exp=10", aq.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < aq.size()) ? aq[i] : 8'hxx;
      n_cmp++; if (got !== 8'(i + 1)) begin n_bad++; $display("FAIL stall_a_word idx=%0d got=%h exp=%h", i, got, 8'(i + 1)); end
    end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got=%0b exp=0", bus.in_ready); end
    n_cmp++; if (src.size() != 3) begin n_bad++; $display("FAIL stall_accepted remaining got=%0d exp=3", src.size()); end
    n_cmp++; if ({bus.b_valid, bus.b_data} !== 9'h101) begin n_bad++; $display("FAIL stall_b_head got=%0b/%h exp=1/01", bus.b_valid, bus.b_data); end
`ifdef STREAM_FORK_OCCUPANCY_EN
    n_cmp++; if (bus.b_count !== 4'd10) begin n_bad++; $display("FAIL stall_b_count got=%0d exp=10", bus.b_count); end
    n_cmp++; if (bus.a_count !== 4'd0) begin n_bad++; $display("FAIL stall_a_count got=%0d exp=0", bus.a_count); end
`endif
    bus.b_ready = 1'b1;
    repeat (40) step();
    n_cmp++; if (bq.size() != 15) begin n_bad++; $display("FAIL release_b_words got=%0d exp=15", bq.size()); end
    for (int i = 0; i < 15; i++) begin
      got = (i < bq.size()) ? bq[i] : 8'hxx;
      n_cmp++; if (got !== 8'(i + 1)) begin n_bad++; $display("FAIL release_b_word idx=%0d got=%h exp=%h", i, got, 8'(i + 1)); end
    end
    n_cmp++; if (aq.size() != 15) begin n_bad++; $display("FAIL release_a_words got=%0d exp=15", aq.size()); end
    for (int i = 10; i < 15; i++) begin
      got = (i < aq.size()) ? aq[i] : 8'hxx;
      n_cmp++; if (got !== 8'(i + 1)) begin n_bad++; $display("FAIL release_a_word idx=%0d got=%h exp=%h", i, got, 8'(i + 1)); end
    end
  endtask

  task automatic test_full_pop();
    aq.delete(); bq.delete();
    bus.a_ready = 1'b0; bus.b_ready = 1'b1;
    for (int i = 1; i <= 12; i++) src.push_back(8'(i));
    load_src();
    repeat (30) step();
    n_cmp++; if ({bus.a_valid, bus.a_data} !== 9'h101) begin n_bad++; $display("FAIL full_a_head got=%0b/%h exp=1/01", bus.a_valid, bus.a_data); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got=%0b exp=0", bus.in_ready); end
`ifdef STREAM_FORK_OCCUPANCY_EN
    n_cmp++; if (bus.a_count !== 4'd10) begin n_bad++; $display("FAIL full_a_count got=%0d exp=10", bus.a_count); end
`endif
    bus.a_ready = 1'b1;
    step();
    n_cmp++; if ({bus.a_valid, bus.a_data} !== 9'h102) begin n_bad++; $display("FAIL pop_a_head got=%0b/%h exp=1/02", bus.a_valid, bus.a_data); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL pop_in_ready got=%0b exp=0", bus.in_ready); end
    n_cmp++; if (bus.b_valid !== 1'b0) begin n_bad++; $display("FAIL pop_no_bypass_b got=%0b exp=0", bus.b_valid); end
`ifdef STREAM_FORK_OCCUPANCY_EN
    n_cmp++; if (bus.a_count !== 4'd9) begin n_bad++; $display("FAIL pop_a_count got=%0d exp=9", bus.a_count); end
`endif
    bus.a_ready = 1'b0;
    step();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL resume_in_ready got=%0b exp=1", bus.in_ready); end
    n_cmp++; if (bus.b_valid !== 1'b0) begin n_bad++; $display("FAIL resume_b_valid got=%0b exp=0", bus.b_valid); end
`ifdef STREAM_FORK_OCCUPANCY_EN
    n_cmp++; if (bus.a_count !== 4'd10) begin n_bad++; $display("FAIL resume_a_count got=%0d exp=10", bus.a_count); end
`endif
    step();
    n_cmp++; if ({bus.b_valid, bus.b_data} !== 9'h10B) begin n_bad++; $display("FAIL resume_b_head got=%0b/%h exp=1/0b", bus.b_valid, bus.b_data); end
    bus.a_ready = 1'b1;
    repeat (30) step();
    n_cmp++; if (aq.size() != 12 || bq.size() != 12) begin n_bad++; $display("FAIL full_drain_words got=%0d/%0d exp=12/12", aq.size(), bq.size()); end
    for (int i = 0; i < 12; i++) begin
      got = (i < aq.size()) ? aq[i] : 8'hxx;
      n_cmp++; if (got !== 8'(i + 1)) begin n_bad++; $display("FAIL full_drain_a idx=%0d got=%h exp=%h", i, got, 8'(i + 1)); end
    end
  endtask

  task automatic test_async_reset();
    aq.delete(); bq.delete();
    bus.a_ready = 1'b1; bus.b_ready = 1'b1;
    for (int i = 1; i <= 8; i++) src.push_back(8'(8'h40 + i));
    load_src();
    repeat (5) step();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%0b/%0b exp=0/0", bus.a_valid, bus.b_valid); end
    n_cmp++; if (bus.a_data !== 8'h00) begin n_bad++; $display("FAIL arst_a_data got=%h exp=00", bus.a_data); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_in_ready got=%0b exp=1", bus.in_ready); end
`ifdef STREAM_FORK_OCCUPANCY_EN
    n_cmp++; if (bus.a_count !== 4'd0 || bus.b_count !== 4'd0) begin n_bad++; $display("FAIL arst_counts got=%0d/%0d exp=0/0", bus.a_count, bus.b_count); end
`endif
    src.delete();
    load_src();
    aq.delete(); bq.delete();
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (10) step();
    n_cmp++; if (aq.size() != 0 || bq.size() != 0) begin n_bad++; $display("FAIL arst_stale got=%0d/%0d exp=0/0", aq.size(), bq.size()); end
  endtask

  task automatic test_wrap();
    int unsigned budget;
    aq.delete(); bq.delete();
    bus.b_ready = 1'b1;
    for (int i = 0; i < 25; i++) src.push_back(8'(8'h80 + i));
    load_src();
    budget = 0;
    while ((aq.size() < 25 || bq.size() < 25) && budget < 400) begin
      bus.a_ready = 1'($urandom_range(0, 1));
      step();
      budget++;
    end
    n_cmp++; if (budget >= 400) begin n_bad++; $display("FAIL wrap_timeout got=%0d/%0d exp=25/25", aq.size(), bq.size()); end
    for (int i = 0; i < 25; i++) begin
      got = (i < aq.size()) ? aq[i] : 8'hxx;
      n_cmp++; if (got !== 8'(8'h80 + i)) begin n_bad++; $display("FAIL wrap_a idx=%0d got=%h exp=%h", i, got, 8'(8'h80 + i)); end
      got = (i < bq.size()) ? bq[i] : 8'hxx;
      n_cmp++; if (got !== 8'(8'h80 + i)) begin n_bad++; $display("FAIL wrap_b idx=%0d got=%h exp=%h", i, got, 8'(8'h80 + i)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall_b();
    test_full_pop();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
